// File: rtl/fix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fix_pkg
// Description : Shared FIX egress definitions: trailer state encoding and
//               protocol byte constants.
// Revision    : 1.0 - initial release
// ============================================================================
package fix_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        BODY = 4'd1,
        T1   = 4'd2,
        T0   = 4'd3,
        EQ   = 4'd4,
        D2   = 4'd5,
        D1   = 4'd6,
        D0   = 4'd7,
        TS   = 4'd8
    } state_t;

    localparam logic [7:0]  SOH          = 8'h01;
    localparam logic [7:0]  ASCII_0      = 8'h30;
    localparam logic [7:0]  ASCII_1      = 8'h31;
    localparam logic [7:0]  ASCII_EQ     = 8'h3D;
    localparam logic [15:0] TAG_CHECKSUM = "10";

endpackage
`default_nettype wire

// File: rtl/checksum_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : checksum_tx_if
// Description : Byte-stream handshake bundle between assembler, trailer
//               generator and serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface checksum_tx_if;

    logic [7:0] data_i;
    logic       valid_i;
    logic       last_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       last_o;
    logic       ready_i;
    logic [7:0] checksum_o;

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o, checksum_o
    );

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, checksum_o
    );

endinterface
`default_nettype wire

// File: rtl/int2ascii.sv
`default_nettype none
// ============================================================================
// Module      : int2ascii
// Description : 8-bit binary to three zero-padded ASCII decimal digits using
//               a compare/subtract chain.
// Revision    : 1.0 - initial release
// ============================================================================
module int2ascii
    import fix_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [7:0] w_rem;
    logic [1:0] w_hund;
    logic [3:0] w_tens;

    always_comb begin
        w_rem  = value;
        w_hund = 2'd0;
        w_tens = 4'd0;
        if (w_rem >= 8'd200) begin
            w_hund = 2'd2;
            w_rem  = w_rem - 8'd200;
        end else if (w_rem >= 8'd100) begin
            w_hund = 2'd1;
            w_rem  = w_rem - 8'd100;
        end
        // Remainder is below 100 here, so nine steps always suffice.
        for (int i = 0; i < 9; i++) begin
            if (w_rem >= 8'd10) begin
                w_rem  = w_rem - 8'd10;
                w_tens = w_tens + 4'd1;
            end
        end
    end

    assign hundreds = ASCII_0 + {6'd0, w_hund};
    assign tens     = ASCII_0 + {4'd0, w_tens};
    assign ones     = ASCII_0 + w_rem;

endmodule
`default_nettype wire

// File: rtl/checksum_tx.sv
`default_nettype none
// ============================================================================
// Module      : checksum_tx
// Description : FIX egress trailer generator; forwards the body and appends
//               "10=NNN<SOH>" carrying the modulo-256 byte sum.
// Revision    : 1.0 - initial release
// ============================================================================
module checksum_tx
    import fix_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    checksum_tx_if.slave  bus
);

    state_t     r_state;
    logic [7:0] r_sum;
    logic [7:0] r_checksum;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_last;

    logic       w_slot_free;
    logic       w_in_body;
    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_sum_next;
    logic [7:0] w_d2;
    logic [7:0] w_d1;
    logic [7:0] w_d0;
    logic [7:0] w_trl_byte;
    state_t     w_trl_next;

    assign w_slot_free = !r_valid || bus.ready_i;
    assign w_in_body   = (r_state == IDLE) || (r_state == BODY);
    assign w_ready     = !rst && w_slot_free && w_in_body;
    assign w_accept    = w_ready && bus.valid_i;
    // The first byte of a message restarts the sum rather than adding to it.
    assign w_sum_next  = (r_state == IDLE) ? bus.data_i : r_sum + bus.data_i;

    int2ascii u_int2ascii (
        .value    (r_checksum),
        .hundreds (w_d2),
        .tens     (w_d1),
        .ones     (w_d0)
    );

    always_comb begin
        w_trl_byte = 8'h00;
        w_trl_next = IDLE;
        case (r_state)
            T1:      begin w_trl_byte = TAG_CHECKSUM[15:8]; w_trl_next = T0; end
            T0:      begin w_trl_byte = TAG_CHECKSUM[7:0];  w_trl_next = EQ; end
            EQ:      begin w_trl_byte = ASCII_EQ;           w_trl_next = D2; end
            D2:      begin w_trl_byte = w_d2;               w_trl_next = D1; end
            D1:      begin w_trl_byte = w_d1;               w_trl_next = D0; end
            D0:      begin w_trl_byte = w_d0;               w_trl_next = TS; end
            TS:      begin w_trl_byte = SOH;                w_trl_next = IDLE; end
            default: begin w_trl_byte = 8'h00;              w_trl_next = IDLE; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sum      <= 8'h00;
            r_checksum <= 8'h00;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum   <= w_sum_next;
                r_state <= bus.last_i ? T1 : BODY;
                if (bus.last_i) begin
                    r_checksum <= w_sum_next;
                end
            end else if (w_slot_free && !w_in_body) begin
                r_state <= w_trl_next;
            end

            if (w_slot_free) begin
                if (w_accept) begin
                    r_data  <= bus.data_i;
                    r_valid <= 1'b1;
                    r_last  <= 1'b0;
                end else if (!w_in_body) begin
                    r_data  <= w_trl_byte;
                    r_valid <= 1'b1;
                    r_last  <= (r_state == TS);
                end else begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            end
        end
    end

    assign bus.ready_o    = w_ready;
    assign bus.data_o     = r_data;
    assign bus.valid_o    = r_valid;
    assign bus.last_o     = r_last;
    assign bus.checksum_o = r_checksum;

endmodule
`default_nettype wire
